func_sweep_ctrl: RTL and testbench

//  Sequencer for the generated sum-of-products function blocks (N inputs, single output F).
//  On start it walks every input vector 0..2^N_IN-1 and drives it onto the DUT inputs.

---
 rtl/func_sweep_pkg.sv | 17 +
 rtl/func_sweep_ctrl_settle_timer.sv | 27 ++
 rtl/func_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_func_sweep_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/func_sweep_pkg.sv
// Shared types for the function-block sweep sequencer: FSM state encoding and counter width helper.
package func_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_LOG,
    ST_DONE
  } state_e;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/func_sweep_ctrl_settle_timer.sv
// Dwell timer for the SETTLE phase: reloads while load is high, counts down to zero otherwise.
module sweep_settle_timer #(
  parameter int unsigned LOAD_VAL = 0,
  parameter int unsigned W        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(LOAD_VAL);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/func_sweep_ctrl.sv
// Exhaustive input sweep sequencer for generated SOP function blocks; counts on-set and mismatches.
// Optional per-hit log handshake enabled by defining FSWEEP_LOG_EN.
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = 10,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] x,
  input  logic            f_dut,
  input  logic            f_ref,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt,
  output logic [N_IN:0]   mism_cnt,
  output logic [N_IN-1:0] first_mism
`ifdef FSWEEP_LOG_EN
  ,
  output logic            log_valid,
  input  logic            log_ready,
  output logic [N_IN-1:0] log_idx
`endif
);

  localparam int unsigned     TMR_W    = cnt_w(SETTLE_CYC);
  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic            busy_q;
  logic            done_q;
  logic [N_IN:0]   ones_q;
  logic [N_IN:0]   mism_q;
  logic [N_IN-1:0] first_q;
  logic            settle_tc;
  logic            adv;

  sweep_settle_timer #(
    .LOAD_VAL (SETTLE_CYC - 1),
    .W        (TMR_W)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_q != ST_SETTLE),
    .en    (1'b1),
    .tc    (settle_tc)
  );

`ifdef FSWEEP_LOG_EN
  logic            log_valid_q;
  logic [N_IN-1:0] log_idx_q;

  // A hit detours through LOG; the vector advance then happens on the handshake instead.
  always_comb begin
    adv = 1'b0;
    if (state_q == ST_SAMPLE) adv = !f_dut;
    if (state_q == ST_LOG)    adv = log_ready;
  end

  assign log_valid = log_valid_q;
  assign log_idx   = log_idx_q;
`else
  always_comb begin
    adv = (state_q == ST_SAMPLE);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ones_q      <= '0;
      mism_q      <= '0;
      first_q     <= '0;
`ifdef FSWEEP_LOG_EN
      log_valid_q <= 1'b0;
      log_idx_q   <= '0;
`endif
    end else if (abort) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FSWEEP_LOG_EN
      log_valid_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_SETTLE;
            idx_q   <= '0;
            ones_q  <= '0;
            mism_q  <= '0;
            first_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_tc) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (f_dut) ones_q <= ones_q + CNT_ONE;
          if (f_dut != f_ref) begin
            mism_q <= mism_q + CNT_ONE;
            if (mism_q == '0) first_q <= idx_q;
          end
`ifdef FSWEEP_LOG_EN
          if (f_dut) begin
            state_q     <= ST_LOG;
            log_valid_q <= 1'b1;
            log_idx_q   <= idx_q;
          end
`endif
        end
`ifdef FSWEEP_LOG_EN
        ST_LOG: begin
          if (log_ready) log_valid_q <= 1'b0;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase

      if (adv) begin
        if (idx_q == IDX_LAST) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q   <= idx_q + IDX_ONE;
          state_q <= ST_SETTLE;
        end
      end
    end
  end

  assign x          = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ones_cnt   = ones_q;
  assign mism_cnt   = mism_q;
  assign first_mism = first_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: N_IN=4 table of functions, reset/abort corners, N_IN=10 run.
module tb_func_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, abort4, start10, abort10;
  logic [3:0] x4;
  logic       f_dut4, f_ref4, busy4, done4;
  logic [4:0] ones4, mism4;
  logic [3:0] first4;
  logic [9:0] x10;
  logic       f10, busy10, done10;
  logic [10:0] ones10, mism10;
  logic [9:0] first10;
  int         mode;
  int         n_chk  = 0;
  int         n_fail = 0;

`ifdef FSWEEP_LOG_EN
  localparam int LOG_EXTRA = 1;
  logic       lv4, lr4, lv10, lr10;
  logic [3:0] li4;
  logic [9:0] li10;
  logic       log_manual;
  int         low_cnt;
  int         log_q[$];
  assign lr10 = 1'b1;
`else
  localparam int LOG_EXTRA = 0;
`endif

  always_comb begin
    f_dut4 = 1'b0;
    f_ref4 = 1'b0;
    case (mode)
      0: begin f_dut4 = x4[0];                    f_ref4 = x4[0];          end
      1: begin f_dut4 = x4[0] ^ (x4 == 4'd6);     f_ref4 = x4[0];          end
      2: begin f_dut4 = x4[1];                    f_ref4 = x4[1];          end
      3: begin f_dut4 = 1'b1;                     f_ref4 = x4[0];          end
      4: begin f_dut4 = (x4 >= 4'd12);            f_ref4 = (x4 >= 4'd13);  end
      5: begin f_dut4 = 1'b0;                     f_ref4 = (x4 == 4'd15);  end
      default: ;
    endcase
    f10 = &x10;
  end

  func_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .x(x4),
    .f_dut(f_dut4), .f_ref(f_ref4), .busy(busy4), .done(done4),
    .ones_cnt(ones4), .mism_cnt(mism4), .first_mism(first4)
`ifdef FSWEEP_LOG_EN
    , .log_valid(lv4), .log_ready(lr4), .log_idx(li4)
`endif
  );

  func_sweep_ctrl #(.N_IN(10), .SETTLE_CYC(3)) u10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .abort(abort10), .x(x10),
    .f_dut(f10), .f_ref(f10), .busy(busy10), .done(done10),
    .ones_cnt(ones10), .mism_cnt(mism10), .first_mism(first10)
`ifdef FSWEEP_LOG_EN
    , .log_valid(lv10), .log_ready(lr10), .log_idx(li10)
`endif
  );

  typedef struct {
    int   mode;
    logic busy_start;
    int   ones;
    int   mism;
    int   first;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start4();
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; also serves the log handshake.
  task automatic wait_done4(input logic bs, output int cyc);
    cyc = 0;
    while (!done4 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      start4 = (bs && cyc == 10);
`ifdef FSWEEP_LOG_EN
      if (!log_manual) lr4 = 1'b1;
      else if (lr4) lr4 = 1'b0;
      else if (lv4) begin
        if (low_cnt == 5) begin
          log_q.push_back(int'(li4));
          lr4     = 1'b1;
          low_cnt = 0;
        end else low_cnt++;
      end
`endif
    end
    start4 = 1'b0;
  endtask

  task automatic wait_x4(input logic [3:0] v);
    int n = 0;
    while (x4 != v && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_x4_reached", int'(x4), int'(v));
  endtask

  initial begin
    int cyc;
    rst_n   = 1'b0;
    start4  = 1'b0; abort4  = 1'b0;
    start10 = 1'b0; abort10 = 1'b0;
    mode    = 0;
`ifdef FSWEEP_LOG_EN
    lr4 = 1'b1; log_manual = 1'b0; low_cnt = 0;
`endif
    tbl[0] = '{0, 1'b0,  8, 0,  0};
    tbl[1] = '{1, 1'b0,  9, 1,  6};
    tbl[2] = '{3, 1'b0, 16, 8,  0};
    tbl[3] = '{4, 1'b0,  4, 1, 12};
    tbl[4] = '{5, 1'b0,  0, 1, 15};
    tbl[5] = '{0, 1'b1,  8, 0,  0};

    #22;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_x",     int'(x4),     0);
    check("rst_busy",  int'(busy4),  0);
    check("rst_done",  int'(done4),  0);
    check("rst_ones",  int'(ones4),  0);
    check("rst_mism",  int'(mism4),  0);
    check("rst_first", int'(first4), 0);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      pulse_start4();
      check("start_busy", int'(busy4), 1);
      wait_done4(tbl[i].busy_start, cyc);
      check("tbl_cycles", cyc, 32 + LOG_EXTRA * tbl[i].ones);
      check("tbl_ones",   int'(ones4),  tbl[i].ones);
      check("tbl_mism",   int'(mism4),  tbl[i].mism);
      check("tbl_first",  int'(first4), tbl[i].first);
      check("tbl_x_last", int'(x4),     15);
      check("tbl_busy",   int'(busy4),  0);
    end

    // Async reset mid-sweep, then a clean restart.
    mode = 0;
    pulse_start4();
    wait_x4(4'd5);
    check("pre_rst_ones", int'(ones4), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x",    int'(x4),    0);
    check("arst_busy", int'(busy4), 0);
    check("arst_ones", int'(ones4), 0);
    @(negedge clk) rst_n = 1'b1;
    pulse_start4();
    wait_done4(1'b0, cyc);
    check("arst_run_cycles", cyc, 32 + LOG_EXTRA * 8);
    check("arst_run_ones",   int'(ones4), 8);
    check("arst_run_mism",   int'(mism4), 0);

    // Abort partway, counters frozen, then restart from zero.
    mode = 1;
    pulse_start4();
    wait_x4(4'd3);
    abort4 = 1'b1;
    @(posedge clk);
    #1 abort4 = 1'b0;
    check("abort_busy", int'(busy4), 0);
    check("abort_done", int'(done4), 0);
    check("abort_ones", int'(ones4), 1);
    check("abort_x",    int'(x4),    3);
    repeat (3) @(posedge clk);
    #1 check("abort_stays_idle", int'(busy4), 0);
    pulse_start4();
    check("restart_x",    int'(x4),    0);
    check("restart_ones", int'(ones4), 0);
    wait_done4(1'b0, cyc);
    check("restart_cycles", cyc, 32 + LOG_EXTRA * 9);
    check("restart_ones_f", int'(ones4),  9);
    check("restart_mism",   int'(mism4),  1);
    check("restart_first",  int'(first4), 6);

    // Wide configuration with a longer dwell.
    @(negedge clk) start10 = 1'b1;
    @(posedge clk);
    #1 start10 = 1'b0;
    cyc = 0;
    while (!done10 && cyc < 10000) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("n10_cycles", cyc, 4096 + LOG_EXTRA);
    check("n10_ones",   int'(ones10), 1);
    check("n10_mism",   int'(mism10), 0);
    check("n10_x",      int'(x10),    1023);
    check("n10_first",  int'(first10), 0);

`ifdef FSWEEP_LOG_EN
    mode       = 2;
    log_manual = 1'b1;
    lr4        = 1'b0;
    low_cnt    = 0;
    pulse_start4();
    wait_done4(1'b0, cyc);
    check("log_count", log_q.size(), 8);
    begin
      int exp_idx[8] = '{2, 3, 6, 7, 10, 11, 14, 15};
      foreach (exp_idx[k]) begin
        if (k < log_q.size()) check("log_idx", log_q[k], exp_idx[k]);
        else                  check("log_idx_missing", -1, exp_idx[k]);
      end
    end
    check("log_ones", int'(ones4), 8);
    check("log_valid_end", int'(lv4), 0);
    log_manual = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
